mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, fixed-latency unified memory between the instruction-fetch stage and the load/store (MEM) stage of the RISC-V core. It has one transaction outstanding at a time. Data requests have priority, and a starvation guard bounds how long fetch can wait. Each granted transaction gets exactly one response pulse, LATENCY cycles after its grant, unless a reset or a fetch flush suppresses it.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LATENCY, 2, memory cycles from `mem_en` to valid `mem_rdata`; must be >= 1
- MAX_WAIT, 4, lost arbitration slots after which fetch overrides data; must be >= 1
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held with `if_addr` until `if_gnt` (may drop early)
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  cancels the response of an outstanding fetch
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid pulse
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request, held with its payload until `d_gnt`
- d_we  in  1  write when 1
- d_be  in  DATA_W/8  byte enables; writes only
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  load data or store acknowledge pulse
- d_rdata  out  DATA_W  load data; undefined for stores
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_be  out  DATA_W/8  byte enables to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  valid LATENCY cycles after `mem_en`
- busy  out  1  a transaction is outstanding

## Operation
- States: IDLE, WAIT. Registered fields: owner {NONE, IF, D}, `lat_cnt`, `wait_cnt`, `killed`.
- **Slot open** when state is IDLE, or state is WAIT with `lat_cnt`==0 (the response cycle).
- **Selection in an open slot:**
  - Fetch wins if `if_req` is high and `wait_cnt`==MAX_WAIT.
  - Otherwise data wins if `d_req` is high.
  - Otherwise fetch wins if `if_req` is high.
- **Grant is combinational in the same cycle:**
  - The winner's gnt is high.
  - `mem_en` is 1 and the winner's address, byte enables, write data and we are muxed to `mem_*`.
  - Fetch forces `mem_we`=0 and `mem_be`='1.
- **On a grant:** state becomes WAIT, owner becomes the winner, `lat_cnt` loads LATENCY-1, `killed` clears.
- **In WAIT with `lat_cnt`>0:** `lat_cnt` decrements by 1. No grant.
- **Response cycle (WAIT, `lat_cnt`==0):**
  - The owner's rvalid is 1 and its rdata equals `mem_rdata`.
  - For owner IF, `if_rvalid` is suppressed if `killed` is set or `if_flush` is high this cycle.
  - If the slot grants again, state stays WAIT (back-to-back). Otherwise state goes to IDLE and owner to NONE.
- **`if_flush`:** while owner is IF in WAIT, sets `killed`. In IDLE it has no effect, and it does not block a fetch grant in the same cycle.
- **`wait_cnt` update, evaluated per open slot:**
  - Increments, saturating at MAX_WAIT, if `if_req` is high and data won.
  - Clears if fetch won or `if_req` is low.
  - Holds otherwise.
- **`busy`:** equals (state==WAIT).
- When a slot is open, a requester's payload is sampled only in its gnt cycle. `mem_*` outputs are don't-care when `mem_en`=0 and are driven to 0.

## Timing
- Grant latency is 0 cycles from req in an open slot. Response arrives exactly LATENCY cycles after the grant cycle.
- Throughput is one transaction per LATENCY cycles. With LATENCY=1, a grant is possible every cycle.
- Reset values: state IDLE, owner NONE, `lat_cnt`=0, `wait_cnt`=0, `killed`=0. All gnt, rvalid, `mem_en` and `busy` outputs are 0. While `reset` is high, gnt and `mem_en` are also forced to 0.
- Reset mid-transaction drops it: no rvalid is ever produced for it. The first grant is possible in the cycle after `reset` deasserts.
- Simultaneous `if_req` and `d_req` with `wait_cnt` below MAX_WAIT: data wins.
- A requester dropping req before gnt (fetch redirect) is legal. No transaction is issued for it.

## Structure
- `common` package gets:
  - `arb_owner_t` enum (NONE, IF, D)
  - `arb_state_t` enum (IDLE, WAIT)
  - `mem_req_t` struct {en, we, be, addr, wdata}
- One combinational sub-module, `arb_select`: inputs `if_req`, `d_req`, `wait_cnt`==MAX_WAIT, slot_open; outputs `grant_if` and `grant_d` (one-hot or zero).
- `mem_arbiter` holds the FSM, counters, payload mux and response routing.

## Test plan
All scenarios use LATENCY=2 and MAX_WAIT=4.
1. Fetch 0x100 alone, memory returns 0xDEADBEEF → `if_gnt` at t0, `mem_addr`=0x100 at t0, `if_rvalid`=1 with 0xDEADBEEF at t2, `busy`=1 for t1..t2.
2. `if_req` and `d_req` (load 0x2000) together at t0 → `d_gnt` at t0, `d_rvalid` at t2, `if_gnt` at t2 (back-to-back), `if_rvalid` at t4.
3. `d_req` held continuously with `if_req` high → data wins 4 slots (t0, t2, t4, t6). `wait_cnt`=4, so `if_gnt` at t8, then data resumes at t10.
4. Store 0x55AA to 0x40 with `d_be`=4'b0011 → `mem_we`=1, `mem_be`=0011, `mem_wdata`=0x55AA at t0; `d_rvalid` ack at t2.
5. Fetch granted at t0, `if_flush` at t1 → no `if_rvalid` at t2, state IDLE at t3. Repeat with `if_flush` at t2 → also suppressed.
6. `reset` asserted at t1 during an outstanding data load → no `d_rvalid`, all outputs 0 during reset. A new `d_req` is granted in the first cycle after `reset` deasserts.

Source files
------------

// File: rtl/common_pkg.sv
// common: types and widths shared by the memory arbiter and its selector.
package common;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W = MEM_DATA_W / 8;
    typedef enum logic [1:0] {NONE, IF, D} arb_owner_t;
    typedef enum logic {IDLE, WAIT} arb_state_t;
    typedef struct packed {
        logic en;
        logic we;
        logic [MEM_BE_W-1:0] be;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/mem_arbiter_select.sv
// arb_select: picks fetch or data for an open memory slot, data first unless fetch is starving.
module arb_select (
    input  logic if_req,
    input  logic d_req,
    input  logic starve,
    input  logic slot_open,
    output logic grant_if,
    output logic grant_d
);
    assign grant_if = slot_open & if_req & (starve | ~d_req);
    assign grant_d = slot_open & d_req & ~(if_req & starve);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between fetch and data with one
// transaction in flight, data priority and a fetch starvation guard.
module mem_arbiter
    import common::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LATENCY = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic if_flush,
    output logic if_gnt,
    output logic if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic d_req,
    input  logic d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic d_gnt,
    output logic d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic mem_en,
    output logic mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic busy
);
    localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic killed_q, killed_d;
    logic slot_open, resp, grant_if, grant_d;
    mem_req_t req;

    // Reset masks the slot and the response so nothing issues or completes while it is held.
    assign slot_open = ~reset & ((state_q == IDLE) | (lat_cnt_q == '0));
    assign resp = ~reset & (state_q == WAIT) & (lat_cnt_q == '0);

    arb_select u_sel (
        .if_req(if_req),
        .d_req(d_req),
        .starve(wait_cnt_q == WW'(MAX_WAIT)),
        .slot_open(slot_open),
        .grant_if(grant_if),
        .grant_d(grant_d)
    );

    assign if_gnt = grant_if;
    assign d_gnt = grant_d;
    assign if_rvalid = resp & (owner_q == IF) & ~killed_q & ~if_flush;
    assign d_rvalid = resp & (owner_q == D);
    assign if_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign busy = ~reset & (state_q == WAIT);

    always_comb begin
        req = '0;
        if (grant_if) begin
            req.en = 1'b1;
            req.be = '1;
            req.addr = MEM_ADDR_W'(if_addr);
        end else if (grant_d) begin
            req.en = 1'b1;
            req.we = d_we;
            req.be = MEM_BE_W'(d_be);
            req.addr = MEM_ADDR_W'(d_addr);
            req.wdata = MEM_DATA_W'(d_wdata);
        end
    end

    assign mem_en = req.en;
    assign mem_we = req.we;
    assign mem_be = req.be[DATA_W/8-1:0];
    assign mem_addr = req.addr[ADDR_W-1:0];
    assign mem_wdata = req.wdata[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        lat_cnt_d = lat_cnt_q;
        killed_d = killed_q;
        wait_cnt_d = wait_cnt_q;
        if (grant_if | grant_d) begin
            state_d = WAIT;
            owner_d = grant_if ? IF : D;
            lat_cnt_d = LW'(LATENCY - 1);
            killed_d = 1'b0;
        end else if (resp) begin
            state_d = IDLE;
            owner_d = NONE;
            killed_d = 1'b0;
        end else if (state_q == WAIT) begin
            lat_cnt_d = lat_cnt_q - 1'b1;
            killed_d = killed_q | ((owner_q == IF) & if_flush);
        end
        if (slot_open)
            wait_cnt_d = (if_req & grant_d) ? ((wait_cnt_q == WW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1)
                       : (grant_if | ~if_req) ? '0 : wait_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= NONE;
            lat_cnt_q <= '0;
            wait_cnt_q <= '0;
            killed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            killed_q <= killed_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle vectors plus starvation and reset sequences for mem_arbiter.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0] d_be;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic ifr;
        logic [31:0] ia;
        logic fl;
        logic dr;
        logic we;
        logic [3:0] be;
        logic [31:0] da;
        logic [31:0] wd;
        logic [31:0] mr;
        logic [6:0] flg;
        logic [3:0] mbe;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic ck;
    } vec_t;

    vec_t vt[26];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [6:0] flags();
        return {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy};
    endfunction

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    initial begin
        // flags: {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}
        vt[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b1000100, 4'hF, 32'h100, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 7'b0010001, 4'h0, 32'h0, 32'h0, 1'b1};
        vt[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000000, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[4]  = '{1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 32'h0, 7'b0100100, 4'hF, 32'h2000, 32'h0, 1'b0};
        vt[5]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[6]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h11112222, 7'b1001101, 4'hF, 32'h200, 32'h0, 1'b1};
        vt[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h33334444, 7'b0010001, 4'h0, 32'h0, 32'h0, 1'b1};
        vt[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000000, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h40, 32'h55AA, 32'h0, 7'b0100110, 4'h3, 32'h40, 32'h55AA, 1'b0};
        vt[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0001001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000000, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[14] = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b1000100, 4'hF, 32'h300, 32'h0, 1'b0};
        vt[15] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[16] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hAAAA, 7'b0000001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[17] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000000, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[18] = '{1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b1000100, 4'hF, 32'h304, 32'h0, 1'b0};
        vt[19] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[20] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hBBBB, 7'b0000001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[21] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000000, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[22] = '{1'b1, 32'h308, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b1000100, 4'hF, 32'h308, 32'h0, 1'b0};
        vt[23] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000001, 4'h0, 32'h0, 32'h0, 1'b0};
        vt[24] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hCCCC, 7'b0010001, 4'h0, 32'h0, 32'h0, 1'b1};
        vt[25] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 7'b0000000, 4'h0, 32'h0, 32'h0, 1'b0};

        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        cmp("reset_flags", 0, 32'(flags()), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cmp("post_reset_flags", 0, 32'(flags()), 32'h0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if_req = vt[i].ifr; if_addr = vt[i].ia; if_flush = vt[i].fl;
            d_req = vt[i].dr; d_we = vt[i].we; d_be = vt[i].be; d_addr = vt[i].da;
            d_wdata = vt[i].wd; mem_rdata = vt[i].mr;
            #1;
            cmp("vec_flags", i, 32'(flags()), 32'(vt[i].flg));
            if (vt[i].flg[2]) begin
                cmp("vec_mem_addr", i, mem_addr, vt[i].ma);
                cmp("vec_mem_be", i, 32'(mem_be), 32'(vt[i].mbe));
            end
            if (vt[i].flg[1]) cmp("vec_mem_wdata", i, mem_wdata, vt[i].mwd);
            if (vt[i].flg[4]) cmp("vec_if_rdata", i, if_rdata, vt[i].mr);
            if (vt[i].flg[3] && vt[i].ck) cmp("vec_d_rdata", i, d_rdata, vt[i].mr);
        end

        // Data held against a waiting fetch: fetch must break through on the fifth slot.
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            idle_inputs();
            if_req = (t <= 8); if_addr = 32'h400;
            d_req = (t <= 10); d_be = 4'hF; d_addr = 32'h600;
            #1;
            cmp("starve_gnt_rv", t, 32'({if_gnt, d_gnt, if_rvalid, d_rvalid}),
                32'({t == 8, t == 0 || t == 2 || t == 4 || t == 6 || t == 10, t == 10,
                     t == 2 || t == 4 || t == 6 || t == 8 || t == 12}));
            if (t == 8) cmp("starve_if_addr", t, mem_addr, 32'h400);
        end

        @(negedge clk);
        idle_inputs();
        d_req = 1'b1; d_be = 4'hF; d_addr = 32'h500;
        #1;
        cmp("rst_seq_flags", 0, 32'(flags()), 32'(7'b0100100));
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            reset = 1'b1;
            d_req = 1'b1; d_addr = 32'h504; mem_rdata = 32'h99;
            #1;
            cmp("rst_seq_flags", t, 32'(flags()), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_rdata = '0;
        #1;
        cmp("rst_seq_flags", 3, 32'(flags()), 32'(7'b0100100));
        cmp("rst_seq_addr", 3, mem_addr, 32'h504);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        cmp("rst_seq_flags", 4, 32'(flags()), 32'(7'b0000001));
        @(negedge clk);
        mem_rdata = 32'h77;
        #1;
        cmp("rst_seq_flags", 5, 32'(flags()), 32'(7'b0001001));
        cmp("rst_seq_rdata", 5, d_rdata, 32'h77);
        @(negedge clk);
        idle_inputs();
        #1;
        cmp("rst_seq_flags", 6, 32'(flags()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
